// File: rtl/led_blinker_bank.sv
// led_blinker_bank: shared tick prescaler driving NUM_CH LED channels,
// each runtime-programmable as off, on, blink or one-shot.
module led_blinker_bank #(
    parameter int CLK_HZ = 27000000,
    parameter int TICK_HZ = 1000,
    parameter int NUM_CH = 4,
    parameter int CNT_W = 16,
    parameter int RST_HALF = 500,
    parameter bit LED_ACTIVE_LOW = 1'b0,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [1:0]        i_cfg_mode,
    input  logic [CNT_W-1:0]  i_cfg_half,
    output logic [NUM_CH-1:0] o_led,
    output logic [NUM_CH-1:0] o_busy,
    output logic              o_tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW = $clog2(DIV);

    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_ONESHOT} mode_t;

    logic [PW-1:0] r_pre;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_pre == PW'(DIV - 1));
    assign o_tick = r_tick;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_wrap ? '0 : r_pre + 1'b1;
            r_tick <= w_wrap;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mode_t            r_mode;
        logic [CNT_W-1:0] r_half;
        logic [CNT_W-1:0] r_cnt;
        logic             r_phase;
        logic             w_wr;
        logic             w_last;

        assign w_wr   = i_cfg_we && (i_cfg_ch == CH_W'(k));
        // a half-period of 0 behaves as 1, so the terminal count is 0
        assign w_last = (r_cnt == ((r_half == '0) ? '0 : r_half - 1'b1));

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_mode  <= (k == 0) ? M_BLINK : M_OFF;
                r_half  <= (k == 0) ? CNT_W'(RST_HALF) : '0;
                r_cnt   <= '0;
                r_phase <= (k == 0);
            end else if (w_wr) begin
                r_mode  <= mode_t'(i_cfg_mode);
                r_half  <= i_cfg_half;
                r_cnt   <= '0;
                r_phase <= (i_cfg_mode != 2'd0);
            end else if (r_tick && (r_mode == M_BLINK || r_mode == M_ONESHOT)) begin
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                r_phase <= w_last ? (r_mode == M_BLINK && !r_phase) : r_phase;
                if (w_last && r_mode == M_ONESHOT) r_mode <= M_OFF;
            end
        end

        assign o_led[k]  = r_phase ^ LED_ACTIVE_LOW;
        assign o_busy[k] = (r_mode == M_ONESHOT);
    end
endmodule

// File: tb/tb_led_blinker_bank.sv
// tb_led_blinker_bank: directed checks of led_blinker_bank with DIV=10, 3 channels,
// using an active-high and an active-low instance driven in parallel.
module tb_led_blinker_bank;
    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_half;
    logic [2:0] o_led, o_busy, o_led_n, o_busy_n;
    logic       o_tick, o_tick_n;
    int         c;
    int         total;
    int         bad;

    led_blinker_bank #(.CLK_HZ(100), .TICK_HZ(10), .NUM_CH(3), .CNT_W(8), .RST_HALF(5),
                       .LED_ACTIVE_LOW(1'b0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
        .i_cfg_mode(cfg_mode), .i_cfg_half(cfg_half),
        .o_led(o_led), .o_busy(o_busy), .o_tick(o_tick));

    led_blinker_bank #(.CLK_HZ(100), .TICK_HZ(10), .NUM_CH(3), .CNT_W(8), .RST_HALF(5),
                       .LED_ACTIVE_LOW(1'b1)) u_dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
        .i_cfg_mode(cfg_mode), .i_cfg_half(cfg_half),
        .o_led(o_led_n), .o_busy(o_busy_n), .o_tick(o_tick_n));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        c++;
    endtask

    task automatic run_to(input int target);
        while (c < target) step();
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_mode = mode;
        cfg_half = half;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (o_led !== 3'b001 || o_led_n !== 3'b110) begin
                bad++;
                $display("FAIL reset_led got=%b/%b want=001/110", o_led, o_led_n);
            end
            total++;
            if (o_busy !== 3'b000 || o_tick !== 1'b0 || o_tick_n !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy_tick got busy=%b tick=%b want busy=000 tick=0", o_busy, o_tick);
            end
        end
        rst_n = 1'b1;
        c = 0;
        for (int i = 1; i <= 101; i++) begin
            step();
            total++;
            if (o_tick !== 1'(i % 10 == 0)) begin
                bad++;
                $display("FAIL heartbeat_tick c=%0d got=%b want=%b", c, o_tick, i % 10 == 0);
            end
            if (i == 50 || i == 51 || i == 100 || i == 101) begin
                total++;
                if (o_led[0] !== 1'(i == 50 || i == 101) || o_led_n[0] !== 1'(i == 51 || i == 100)) begin
                    bad++;
                    $display("FAIL heartbeat_led0 c=%0d got=%b/%b", c, o_led[0], o_led_n[0]);
                end
            end
        end
    endtask

    task automatic test_blink();
        int         tc[9] = '{102, 120, 121, 140, 141, 150, 151, 160, 161};
        logic [2:0] tl[9] = '{3'b101, 3'b101, 3'b001, 3'b001, 3'b101, 3'b101, 3'b100, 3'b100, 3'b000};
        cfg(2'd2, 2'd2, 8'd2);
        for (int i = 0; i < 9; i++) begin
            run_to(tc[i]);
            total++;
            if (o_led !== tl[i] || o_led_n !== ~tl[i]) begin
                bad++;
                $display("FAIL blink_led c=%0d got=%b/%b want=%b/%b", c, o_led, o_led_n, tl[i], ~tl[i]);
            end
        end
        cfg(2'd2, 2'd0, 8'd0);
    endtask

    task automatic test_oneshot();
        int         tc[7] = '{163, 190, 191, 211, 221, 240, 241};
        logic [2:0] tl[7] = '{3'b010, 3'b010, 3'b000, 3'b011, 3'b011, 3'b011, 3'b001};
        logic [2:0] tb[7] = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
        cfg(2'd1, 2'd3, 8'd3);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) cfg(2'd1, 2'd3, 8'd3);
            if (i == 4) begin
                run_to(214);
                cfg(2'd1, 2'd3, 8'd3);
            end
            run_to(tc[i]);
            total++;
            if (o_led !== tl[i] || o_led_n !== ~tl[i]) begin
                bad++;
                $display("FAIL oneshot_led c=%0d got=%b/%b want=%b/%b", c, o_led, o_led_n, tl[i], ~tl[i]);
            end
            total++;
            if (o_busy !== tb[i] || o_busy_n !== tb[i]) begin
                bad++;
                $display("FAIL oneshot_busy c=%0d got=%b/%b want=%b", c, o_busy, o_busy_n, tb[i]);
            end
        end
    endtask

    task automatic test_edge();
        int         tc[12] = '{242, 250, 251, 261, 271, 272, 280, 281, 283, 300, 301, 311};
        logic [2:0] tl[12] = '{3'b011, 3'b011, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010,
                               3'b100, 3'b100, 3'b101, 3'b101};
        cfg(2'd1, 2'd2, 8'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) cfg(2'd3, 2'd1, 8'd1);
            if (i == 8) begin
                cfg(2'd1, 2'd0, 8'd0);
                cfg(2'd2, 2'd1, 8'd0);
            end
            run_to(tc[i]);
            total++;
            if (o_led !== tl[i] || o_led_n !== ~tl[i] || o_busy !== 3'b000) begin
                bad++;
                $display("FAIL edge_led c=%0d got=%b/%b busy=%b want=%b/%b busy=000",
                         c, o_led, o_led_n, o_busy, tl[i], ~tl[i]);
            end
        end
        cfg(2'd2, 2'd0, 8'd0);
    endtask

    task automatic test_simultaneous();
        int         tc[5] = '{321, 331, 341, 350, 351};
        logic [2:0] tl[5] = '{3'b101, 3'b101, 3'b001, 3'b001, 3'b000};
        run_to(320);
        total++;
        if (o_tick !== 1'b1) begin
            bad++;
            $display("FAIL simul_tick c=%0d got=%b want=1", c, o_tick);
        end
        cfg(2'd2, 2'd2, 8'd2);
        for (int i = 0; i < 5; i++) begin
            run_to(tc[i]);
            total++;
            if (o_led !== tl[i] || o_led_n !== ~tl[i]) begin
                bad++;
                $display("FAIL simul_led c=%0d got=%b/%b want=%b/%b", c, o_led, o_led_n, tl[i], ~tl[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg(2'd1, 2'd3, 8'd3);
        total++;
        if (o_led !== 3'b010 || o_busy !== 3'b010) begin
            bad++;
            $display("FAIL midrst_pre c=%0d got led=%b busy=%b want led=010 busy=010", c, o_led, o_busy);
        end
        run_to(355);
        rst_n = 1'b0;
        step();
        total++;
        if (o_led !== 3'b001 || o_led_n !== 3'b110 || o_busy !== 3'b000 || o_tick !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state c=%0d got led=%b/%b busy=%b tick=%b want 001/110 000 0",
                     c, o_led, o_led_n, o_busy, o_tick);
        end
        rst_n = 1'b1;
        run_to(365);
        total++;
        if (o_tick !== 1'b0) begin
            bad++;
            $display("FAIL midrst_tick9 c=%0d got=%b want=0", c, o_tick);
        end
        run_to(366);
        total++;
        if (o_tick !== 1'b1) begin
            bad++;
            $display("FAIL midrst_tick10 c=%0d got=%b want=1", c, o_tick);
        end
        run_to(406);
        total++;
        if (o_led !== 3'b001 || o_led_n !== 3'b110) begin
            bad++;
            $display("FAIL midrst_led406 got=%b/%b want=001/110", o_led, o_led_n);
        end
        run_to(407);
        total++;
        if (o_led !== 3'b000 || o_led_n !== 3'b111) begin
            bad++;
            $display("FAIL midrst_led407 got=%b/%b want=000/111", o_led, o_led_n);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_mode = '0;
        cfg_half = '0;
        c = 0;
        total = 0;
        bad = 0;
        test_reset();
        test_blink();
        test_oneshot();
        test_edge();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_blinker_bank.md
# led_blinker_bank

Multi-channel LED blinker that replaces the single fixed-rate toggler. It has one shared prescaler that turns `i_clk` into a periodic tick. It also has `NUM_CH` independent channels, each with a runtime-programmable mode (off, on, blink, one-shot) and a half-period counted in ticks. It sits between board-level control logic and the LED pins, and drives status and heartbeat indicators.

## Interface
- `CLK_HZ`, default 27000000: input clock frequency.
- `TICK_HZ`, default 1000: tick rate. `DIV = CLK_HZ/TICK_HZ` (integer division), required ≥ 2.
- `NUM_CH`, default 4: number of LED channels, ≥ 1.
- `CNT_W`, default 16: width of the half-period and tick counters.
- `RST_HALF`, default 500: channel 0 half-period after reset. 0.5 s at the defaults.
- `LED_ACTIVE_LOW`, default 0: when 1, every `o_led` bit is inverted.
- `CH_W` (localparam): `max(1, clog2(NUM_CH))`.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset. Synchronous and active-low.
- `i_cfg_we`, in, 1: configuration write strobe, one cycle.
- `i_cfg_ch`, in, `CH_W`: target channel.
- `i_cfg_mode`, in, 2: 0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
- `i_cfg_half`, in, `CNT_W`: half-period in ticks. 0 is treated as 1.
- `o_led`, out, `NUM_CH`: registered LED drive.
- `o_busy`, out, `NUM_CH`: channel is in ONESHOT and its pulse is still running.
- `o_tick`, out, 1: one-cycle pulse per tick.

## Operation
- **Prescaler**
  - Counts 0..DIV-1.
  - When the count equals DIV-1, it wraps to 0 and `o_tick` is asserted for that cycle (registered).
  - The tick period is exactly DIV clocks; there is no +1 overshoot.
- **Per-channel state:** `mode` (2b), `half` (`CNT_W`), `cnt` (`CNT_W`), `phase` (1b).
  - `o_led[k] = phase[k] ^ LED_ACTIVE_LOW`.
  - `o_busy[k] = (mode == ONESHOT)`.
- **Config write** (`i_cfg_we` = 1 and `i_cfg_ch` < `NUM_CH`):
  - Loads `mode` and `half`, and clears `cnt`.
  - Sets `phase` to 0 for OFF and to 1 for ON, BLINK and ONESHOT.
  - Writes with `i_cfg_ch` ≥ `NUM_CH` are ignored with no side effects.
- **On a tick, for each channel not being written that cycle:**
  - OFF and ON: no change.
  - BLINK: if `cnt == eff_half-1`, toggle `phase` and set `cnt` to 0; otherwise increment `cnt`. `eff_half = (half == 0) ? 1 : half`.
  - ONESHOT: if `cnt == eff_half-1`, set `phase` to 0, `mode` to OFF and `cnt` to 0; otherwise increment `cnt`.
- **Simultaneous write and tick on the same channel:** the write wins and the tick is dropped for that channel only. Other channels still advance.
- **`cnt` width:** never exceeds `eff_half-1`, so it cannot wrap.

## Timing
- **Reset** (`i_rst_n` low at a rising edge):
  - Prescaler = 0 and `o_tick` = 0.
  - Channel 0: BLINK, `half=RST_HALF`, `cnt=0`, `phase=1`.
  - All other channels: OFF, `phase=0`.
  - `o_busy` = 0.
  - Reset mid-operation aborts every pulse and blink immediately, with these values on the next cycle.
- **Write latency:** a write sampled at edge N is visible on `o_led`/`o_busy` after edge N. That is 1 cycle.
- **BLINK timing:**
  - The first toggle happens at the `eff_half`-th `o_tick` after the write.
  - Period = 2·`eff_half`·DIV clocks.
  - The phase relative to the prescaler is not reset by a write.
- **ONESHOT timing:**
  - LED stays on until the `eff_half`-th tick after the write.
  - `o_led` and `o_busy` fall together in the cycle after that tick.
  - Rewriting ONESHOT while busy restarts the pulse.
- **Tick latency:** a channel update caused by a tick appears in the same cycle `o_tick` is high, and is visible after that edge.

## Test plan
Bench parameters: `CLK_HZ=100`, `TICK_HZ=10` (DIV=10), `NUM_CH=3` (CH_W=2), `CNT_W=8`, `RST_HALF=5`.

1. **Reset and heartbeat.** Hold `i_rst_n` low for 3 cycles, then release.
   - During reset: `o_led=3'b001`, `o_busy=0`, `o_tick=0`.
   - After release: `o_tick` pulses every 10 cycles.
   - `o_led[0]` toggles every 50 cycles.
2. **BLINK with half=2 on ch2.**
   - `o_led[2]` goes to 1 one cycle after the write.
   - It toggles on the 2nd tick, then every 20 cycles (period 40).
   - `o_led[0]` is unaffected.
3. **ONESHOT on ch1, half=3.**
   - `o_led[1]=1` and `o_busy[1]=1` until the 3rd tick; both then fall to 0 and the mode reads OFF.
   - Rewriting at tick 2 extends the pulse to 3 ticks counted from the rewrite.
4. **Edge cases.**
   - BLINK with half=0 on ch1 toggles on every tick.
   - A write to ch=3 leaves every output unchanged.
   - ON and OFF writes drive 1 and 0 and stay static across ticks.
5. **Simultaneous events.**
   - A write to ch2 in the same cycle as `o_tick`: ch2 loads with `cnt=0` and ignores that tick, while ch0 still advances.
   - `i_rst_n` low mid-pulse: outputs return to the reset values next cycle.
6. **Polarity.** With `LED_ACTIVE_LOW=1`, after reset `o_led=3'b110`, and every scenario above shows the bitwise inverse of the LED drive.
